// File: rtl/dualport_ram_pkg.sv
// Shared types and constants for the lane-enabled dual-port RAM.
// FSM states and same-address collision policy encodings.
package dualport_ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int COLL_WRITE_FIRST = 0;
  localparam int COLL_READ_FIRST  = 1;

endpackage

// File: rtl/dualport_ram_init_ctrl.sv
// Init engine: sweeps every address once after reset or clear, then
// hands the memory over to the user ports.
module dualport_ram_init_ctrl
  import dualport_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  busy,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr
);

  state_t                state_q;
  state_t                state_n;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    case (state_q)
      INIT: begin
        if (clear) begin
          ptr_n = '0;
        end else if (&ptr_q) begin
          state_n = RUN;
          ptr_n   = '0;
        end else begin
          ptr_n = ptr_q + 1'b1;
        end
      end
      RUN: begin
        if (clear) begin
          state_n = INIT;
          ptr_n   = '0;
        end
      end
      default: begin
        state_n = INIT;
        ptr_n   = '0;
      end
    endcase
  end

  assign busy      = (state_q == INIT);
  assign init_we   = busy;
  assign init_addr = ptr_q;

endmodule

// File: rtl/dualport_ram_lanes.sv
// Simple dual-port RAM with per-lane write enables, selectable read latency,
// configurable same-address collision policy and a self-clearing init engine.
module dualport_ram_lanes
  import dualport_ram_pkg::*;
#(
  parameter int                  ADDR_WIDTH     = 2,
  parameter int                  DATA_WIDTH     = 8,
  parameter int                  LANE_WIDTH     = 4,
  parameter int                  RD_LATENCY     = 1,
  parameter int                  COLLISION_MODE = COLL_WRITE_FIRST,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
  localparam int                 NUM_LANES      = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_LANES-1:0]  wr_lane_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lane_width
    $error("dualport_ram_lanes: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_rd_latency
    $error("dualport_ram_lanes: RD_LATENCY must be 1 or 2");
  end

  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NUM_LANES-1:0]  lane_en
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_en[i]) merged[i*LANE_WIDTH +: LANE_WIDTH] = new_word[i*LANE_WIDTH +: LANE_WIDTH];
    end
    return merged;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word_p0;

  dualport_ram_init_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_init_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .busy     (busy),
    .init_we  (init_we),
    .init_addr(init_addr)
  );

  // clear wins over user requests sampled at the same edge
  assign wr_acc    = wr_en && !busy && !clear;
  assign rd_acc    = rd_en && !busy && !clear;
  assign wr_merged = lane_merge(mem[wr_addr], wr_data, wr_lane_en);

  always_comb begin
    rd_word_p0 = mem[rd_addr];
    if ((COLLISION_MODE == COLL_WRITE_FIRST) && wr_acc && (wr_addr == rd_addr)) begin
      rd_word_p0 = wr_merged;
    end
  end

  // ---- stage p0: array write port ----
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= INIT_VALUE;
    end else if (wr_acc) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  if (RD_LATENCY == 1) begin : g_rd_lat1
    // ---- stage p1: output register ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= rd_word_p0;
      end
    end
  end else begin : g_rd_lat2
    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic                  vld_p1;

    // ---- stage p1: pipeline register ----
    always_ff @(posedge clk) begin
      if (rd_acc) rd_data_p1 <= rd_word_p0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= rd_acc;
      end
    end

    // ---- stage p2: output register, in-flight read flushed by clear ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= vld_p1 && !clear;
        if (vld_p1 && !clear) rd_data <= rd_data_p1;
      end
    end
  end

endmodule

// File: tb/tb_dualport_ram_lanes.sv
// Bench for dualport_ram_lanes: three instances (write-first, read-first,
// two-cycle latency) share stimulus and are compared with a behavioural model.
module tb_dualport_ram_lanes;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] wr_lane_en;
  logic       rd_en;
  logic [1:0] rd_addr;

  logic       busy_a, busy_b, busy_c;
  logic [7:0] rd_data_a, rd_data_b, rd_data_c;
  logic       rd_valid_a, rd_valid_b, rd_valid_c;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] mem_m [4];
  logic       m_busy;
  int         m_ptr;
  logic       e_val_a, e_val_b, e_val_c;
  logic [7:0] e_dat_a, e_dat_b, e_dat_c;
  logic       pend_v;
  logic [7:0] pend_d;

  dualport_ram_lanes #(.RD_LATENCY(1), .COLLISION_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_lane_en(wr_lane_en),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a));

  dualport_ram_lanes #(.RD_LATENCY(1), .COLLISION_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_lane_en(wr_lane_en),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b));

  dualport_ram_lanes #(.RD_LATENCY(2), .COLLISION_MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_c),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_lane_en(wr_lane_en),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("busy_a", 32'(busy_a), 32'(m_busy));
    chk("busy_b", 32'(busy_b), 32'(m_busy));
    chk("busy_c", 32'(busy_c), 32'(m_busy));
    chk("rd_valid_a", 32'(rd_valid_a), 32'(e_val_a));
    chk("rd_valid_b", 32'(rd_valid_b), 32'(e_val_b));
    chk("rd_valid_c", 32'(rd_valid_c), 32'(e_val_c));
    chk("rd_data_a", 32'(rd_data_a), 32'(e_dat_a));
    chk("rd_data_b", 32'(rd_data_b), 32'(e_dat_b));
    chk("rd_data_c", 32'(rd_data_c), 32'(e_dat_c));
  endtask

  task automatic drive(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                       input logic [1:0] wl, input logic re, input logic [1:0] ra,
                       input logic clr);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_lane_en = wl;
    rd_en = re; rd_addr = ra; clear = clr;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 8'h00, 2'b00, 1'b0, 2'd0, 1'b0);
  endtask

  // One clock: the model applies the rules to the inputs seen at the edge,
  // then all outputs are compared on the falling edge.
  task automatic step();
    logic [7:0] old_word;
    @(posedge clk);
    if (pend_v && !clear) begin
      e_val_c = 1'b1;
      e_dat_c = pend_d;
    end else begin
      e_val_c = 1'b0;
    end
    pend_v = 1'b0;
    if (m_busy) begin
      mem_m[m_ptr] = 8'h00;
      e_val_a = 1'b0;
      e_val_b = 1'b0;
      if (clear) m_ptr = 0;
      else if (m_ptr == 3) begin m_busy = 1'b0; m_ptr = 0; end
      else m_ptr = m_ptr + 1;
    end else if (clear) begin
      m_busy = 1'b1;
      m_ptr = 0;
      e_val_a = 1'b0;
      e_val_b = 1'b0;
    end else begin
      old_word = mem_m[rd_addr];
      if (wr_en) begin
        for (int i = 0; i < 2; i++)
          if (wr_lane_en[i]) mem_m[wr_addr][i*4 +: 4] = wr_data[i*4 +: 4];
      end
      if (rd_en) begin
        e_val_a = 1'b1; e_dat_a = mem_m[rd_addr];
        e_val_b = 1'b1; e_dat_b = old_word;
        pend_v  = 1'b1; pend_d  = mem_m[rd_addr];
      end else begin
        e_val_a = 1'b0;
        e_val_b = 1'b0;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    m_busy = 1'b1; m_ptr = 0; pend_v = 1'b0;
    e_val_a = 1'b0; e_val_b = 1'b0; e_val_c = 1'b0;
    e_dat_a = 8'h00; e_dat_b = 8'h00; e_dat_c = 8'h00;
    for (int i = 0; i < 4; i++) mem_m[i] = 'x;
    check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_inputs(input int clear_odds);
    drive(1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 2'($urandom),
          1'($urandom_range(0, 1)), 2'($urandom),
          1'($urandom_range(0, clear_odds - 1) == 0));
  endtask

  task automatic wait_init(input string tag);
    int bc;
    bc = 0;
    while (busy_a && bc < 20) begin
      bc++;
      random_inputs(1000);
      clear = 1'b0;
      step();
    end
    chk(tag, 32'(bc), 32'd4);
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    do_reset();

    // reset release: four busy cycles, requests ignored meanwhile
    wait_init("busy_len_after_reset");
    for (int a = 0; a < 4; a++) begin
      drive(1'b0, 2'd0, 8'h00, 2'b00, 1'b1, 2'(a), 1'b0);
      step();
      chk("init_read_zero", 32'(rd_data_a), 32'h00);
    end

    // partial lane write on address 1
    drive(1'b1, 2'd1, 8'hA5, 2'b11, 1'b0, 2'd0, 1'b0); step();
    drive(1'b1, 2'd1, 8'h3C, 2'b01, 1'b0, 2'd0, 1'b0); step();
    drive(1'b1, 2'd1, 8'hEE, 2'b00, 1'b0, 2'd0, 1'b0); step();
    drive(1'b0, 2'd0, 8'h00, 2'b00, 1'b1, 2'd1, 1'b0); step();
    chk("lane_merge_addr1", 32'(rd_data_a), 32'hAC);

    // same-address collision
    drive(1'b1, 2'd2, 8'h11, 2'b11, 1'b0, 2'd0, 1'b0); step();
    drive(1'b1, 2'd2, 8'hFF, 2'b10, 1'b1, 2'd2, 1'b0); step();
    chk("collision_write_first", 32'(rd_data_a), 32'hF1);
    chk("collision_read_first", 32'(rd_data_b), 32'h11);
    idle(); step();
    chk("collision_lat2", 32'(rd_data_c), 32'hF1);

    // back-to-back reads, all addresses
    drive(1'b1, 2'd0, 8'h5A, 2'b11, 1'b0, 2'd0, 1'b0); step();
    drive(1'b1, 2'd3, 8'hC7, 2'b11, 1'b0, 2'd0, 1'b0); step();
    for (int a = 0; a < 4; a++) begin
      drive(1'b0, 2'd0, 8'h00, 2'b00, 1'b1, 2'(a), 1'b0);
      step();
    end
    idle(); step();
    chk("lat2_last_valid", 32'(rd_valid_c), 32'd1);
    chk("lat2_last_data", 32'(rd_data_c), 32'hC7);
    idle(); step();

    // randomized traffic with occasional clear
    for (int n = 0; n < 300; n++) begin
      random_inputs(30);
      step();
    end
    idle();
    repeat (6) step();

    // clear while a two-cycle read is in flight and a write targets addr 3
    drive(1'b1, 2'd3, 8'h77, 2'b11, 1'b0, 2'd0, 1'b0); step();
    drive(1'b0, 2'd0, 8'h00, 2'b00, 1'b1, 2'd3, 1'b0); step();
    drive(1'b1, 2'd3, 8'h99, 2'b11, 1'b1, 2'd3, 1'b1); step();
    chk("flush_rd_valid_c", 32'(rd_valid_c), 32'd0);
    chk("flush_busy", 32'(busy_a), 32'd1);
    wait_init("busy_len_after_clear");
    drive(1'b0, 2'd0, 8'h00, 2'b00, 1'b1, 2'd3, 1'b0); step();
    chk("addr3_after_clear", 32'(rd_data_a), 32'h00);
    idle(); step();
    chk("addr3_after_clear_lat2", 32'(rd_data_c), 32'h00);

    // asynchronous reset during traffic
    for (int n = 0; n < 20; n++) begin
      random_inputs(1000);
      step();
    end
    do_reset();
    wait_init("busy_len_after_second_reset");
    for (int n = 0; n < 100; n++) begin
      random_inputs(40);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
